// File: rtl/shared_ram_arbiter.sv
// Two-requester round-robin arbiter for a shared RAM/IO bus.
// Latches the winner's access, decodes chip selects, stalls the loser.
module shared_ram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int SEL_W         = 3,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic                 we_a,
  input  logic [DATA_W-1:0]    wdata_a,
  output logic [DATA_W-1:0]    rdata_a,
  output logic                 ack_a,
  output logic                 wait_n_a,
  input  logic                 req_b,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic                 we_b,
  input  logic [DATA_W-1:0]    wdata_b,
  output logic [DATA_W-1:0]    rdata_b,
  output logic                 ack_b,
  output logic                 wait_n_b,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [2**SEL_W-1:0]  cs_n
);

  localparam int CS_W = 2**SEL_W;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              last_q;
  logic              win_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;
  logic              ack_a_q;
  logic              ack_b_q;
  logic [CS_W-1:0]   cs_n_q;
  logic              ram_we_q;

  logic              gnt_b;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [CS_W-1:0] decode(
    input logic [ADDR_W-1:0] a
  );
    logic [CS_W-1:0] v;
    v = '1;
    v[a[ADDR_W-1 -: SEL_W]] = 1'b0;
    return v;
  endfunction

  // last_q = 1 means B was served last, so A wins a tie.
  always_comb begin
    gnt_b = req_b;
    if (req_a && req_b) begin
      gnt_b = ~last_q;
    end
    sel_addr  = gnt_b ? addr_b  : addr_a;
    sel_we    = gnt_b ? we_b    : we_a;
    sel_wdata = gnt_b ? wdata_b : wdata_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      cs_n_q    <= '1;
      ram_we_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          if (req_a || req_b) begin
            win_q    <= gnt_b;
            last_q   <= gnt_b;
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            wdata_q  <= sel_wdata;
            cnt_q    <= CNT_INIT;
            cs_n_q   <= decode(sel_addr);
            ram_we_q <= sel_we;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) begin
              if (win_q) rdata_b_q <= ram_rdata;
              else       rdata_a_q <= ram_rdata;
            end
            cs_n_q   <= '1;
            ram_we_q <= 1'b0;
            ack_a_q  <= ~win_q;
            ack_b_q  <= win_q;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign ram_addr  = addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign cs_n      = cs_n_q;

  assign wait_n_a  = ~(req_a & ~ack_a_q);
  assign wait_n_b  = ~(req_b & ~ack_b_q);

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter.
// Steps are one cycle apart; outputs are checked 1 ns after the rising edge.
module tb_shared_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        ack_a, ack_b, wait_n_a, wait_n_b;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  cs_n;

  int total = 0;
  int passed = 0;

  shared_ram_arbiter #(
    .ADDR_W(16), .DATA_W(8), .SEL_W(3), .ACCESS_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .we_a(we_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .ack_a(ack_a), .wait_n_a(wait_n_a),
    .req_b(req_b), .addr_b(addr_b), .we_b(we_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .ack_b(ack_b), .wait_n_b(wait_n_b),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    ram_rdata = '0;
    tick();
    tick();
    chk("rst_cs", cs_n, 8'hFF);
    chk("rst_we", ram_we, 0);
    chk("rst_ack", {ack_a, ack_b}, 0);
    chk("rst_rd", {rdata_a, rdata_b}, 0);
    chk("rst_bus", {ram_addr, ram_wdata}, 0);
    chk("rst_wait", {wait_n_a, wait_n_b}, 2'b11);
    reset = 1'b0;
    tick();

    // 1: A reads 0x4123 (top bits 010 -> cs bit 2)
    req_a = 1; addr_a = 16'h4123; we_a = 0; ram_rdata = 8'h5A;
    #1;
    chk("t1_waitN", wait_n_a, 0);
    chk("t1_csN", cs_n, 8'hFF);
    tick();
    chk("t1_cs1", cs_n, 8'b11111011);
    chk("t1_addr", ram_addr, 16'h4123);
    chk("t1_wait1", wait_n_a, 0);
    tick();
    chk("t1_cs2", cs_n, 8'b11111011);
    chk("t1_ack2", ack_a, 0);
    tick();
    chk("t1_ack", {ack_a, ack_b}, 2'b10);
    chk("t1_cs3", cs_n, 8'hFF);
    chk("t1_rd", rdata_a, 8'h5A);
    chk("t1_wait3", wait_n_a, 1);
    req_a = 0;
    tick();
    chk("t1_ack4", ack_a, 0);

    // 2: B writes 0xC3 to 0xE000
    req_b = 1; addr_b = 16'hE000; we_b = 1; wdata_b = 8'hC3;
    ram_rdata = 8'h99;
    tick();
    chk("t2_cs1", cs_n, 8'b01111111);
    chk("t2_we1", ram_we, 1);
    chk("t2_wd", ram_wdata, 8'hC3);
    tick();
    chk("t2_cs2", cs_n, 8'b01111111);
    chk("t2_we2", ram_we, 1);
    tick();
    chk("t2_ack", {ack_a, ack_b}, 2'b01);
    chk("t2_we3", ram_we, 0);
    chk("t2_rdb", rdata_b, 8'h00);
    req_b = 0; we_b = 0;
    tick();
    chk("t2_ack4", ack_b, 0);

    // 3: simultaneous requests right after reset
    reset = 1;
    tick();
    reset = 0;
    tick();
    req_a = 1; addr_a = 16'h2000; we_a = 0;
    req_b = 1; addr_b = 16'h6000; we_b = 0;
    ram_rdata = 8'h11;
    #1;
    chk("t3_wbN", wait_n_b, 0);
    tick();
    chk("t3_cs1", cs_n, 8'b11111101);
    chk("t3_wb1", wait_n_b, 0);
    tick();
    chk("t3_cs2", cs_n, 8'b11111101);
    tick();
    chk("t3_acka", {ack_a, ack_b}, 2'b10);
    chk("t3_wb3", wait_n_b, 0);
    req_a = 0;
    tick();
    chk("t3_cs4", cs_n, 8'hFF);
    chk("t3_wb4", wait_n_b, 0);
    ram_rdata = 8'h22;
    tick();
    chk("t3_cs5", cs_n, 8'b11110111);
    chk("t3_wb5", wait_n_b, 0);
    tick();
    chk("t3_cs6", cs_n, 8'b11110111);
    chk("t3_wb6", wait_n_b, 0);
    tick();
    chk("t3_ackb", {ack_a, ack_b}, 2'b01);
    chk("t3_rdb", rdata_b, 8'h22);
    chk("t3_rda", rdata_a, 8'h11);
    chk("t3_wb7", wait_n_b, 1);
    req_b = 0;
    tick();

    // 4: both held for six accesses; B was last, so A leads
    req_a = 1; req_b = 1;
    for (int i = 0; i < 6; i++) begin
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (ack_a || ack_b) seen = 1;
      end
      chk($sformatf("t4_ack%0d", i), {ack_a, ack_b},
          (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    req_a = 0; req_b = 0;
    tick();
    tick();

    // 5: reset during the second access cycle of an A write
    req_a = 1; addr_a = 16'hA000; we_a = 1; wdata_a = 8'h77;
    tick();
    chk("t5_cs1", cs_n, 8'b11011111);
    chk("t5_we1", ram_we, 1);
    tick();
    chk("t5_cs2", cs_n, 8'b11011111);
    reset = 1;
    tick();
    chk("t5_rcs", cs_n, 8'hFF);
    chk("t5_rwe", ram_we, 0);
    chk("t5_rack", ack_a, 0);
    chk("t5_rbus", {ram_addr, ram_wdata}, 0);
    chk("t5_rwait", wait_n_a, 0);
    reset = 0;
    tick();
    chk("t5_cs1b", cs_n, 8'b11011111);
    chk("t5_addr", ram_addr, 16'hA000);
    chk("t5_wd", ram_wdata, 8'h77);
    tick();
    chk("t5_cs2b", cs_n, 8'b11011111);
    tick();
    chk("t5_ack", {ack_a, ack_b}, 2'b10);
    req_a = 0; we_a = 0;
    tick();

    // 6: A drops req mid-access; B's address sampled at its grant
    req_a = 1; addr_a = 16'h0010; ram_rdata = 8'h33;
    tick();
    chk("t6_cs1", cs_n, 8'b11111110);
    req_b = 1; addr_b = 16'h4000; we_b = 0;
    tick();
    req_a = 0;
    chk("t6_cs2", cs_n, 8'b11111110);
    tick();
    chk("t6_acka", {ack_a, ack_b}, 2'b10);
    chk("t6_rda", rdata_a, 8'h33);
    chk("t6_wb", wait_n_b, 0);
    addr_b = 16'h8000; ram_rdata = 8'h44;
    tick();
    tick();
    addr_b = 16'hFFFF;
    chk("t6_addr1", ram_addr, 16'h8000);
    chk("t6_cs_b", cs_n, 8'b11101111);
    tick();
    chk("t6_addr2", ram_addr, 16'h8000);
    tick();
    chk("t6_ackb", {ack_a, ack_b}, 2'b01);
    chk("t6_rdb", rdata_b, 8'h44);
    req_b = 0;
    tick();
    chk("t6_idle", {ack_a, ack_b, cs_n}, 10'h0FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
